// File: rtl/io_pad_pkg.sv
// io_pad_pkg
// Shared definitions for the pad-control slice: bit positions inside the
// per-pad configuration byte, reset values, the irq-status address window
// and the packed view of a configuration byte.
// No ports; imported by io_pad_ctrl and io_sync_edge.
package io_pad_pkg;

   // Bit positions inside one per-pad configuration byte
   localparam int CFG_IE       = 0;
   localparam int CFG_PU       = 1;
   localparam int CFG_PD       = 2;
   localparam int CFG_CS       = 3;
   localparam int CFG_SL       = 4;
   localparam int CFG_OE_EN    = 5;
   localparam int CFG_IRQ_EN   = 6;
   localparam int CFG_IRQ_FALL = 7;

   // Pads come out of reset as plain inputs: input buffer on, all else off
   localparam logic [7:0] CFG_RESET = 8'h01;

   // First address of the irq status bytes; six bytes cover up to 48 pads
   localparam logic [5:0] STATUS_BASE  = 6'h30;
   localparam logic [5:0] STATUS_LAST  = 6'h35;

   // Packed view of a configuration byte, MSB first
   typedef struct packed {
      logic irq_fall;
      logic irq_en;
      logic oe_en;
      logic sl;
      logic cs;
      logic pd;
      logic pu;
      logic ie;
   } cfg_t;

   // Pull-up and pull-down together would fight on the pad, so pull-down
   // wins and the stored pull-up bit is cleared so readback shows the truth.
   function automatic cfg_t sanitize_cfg(input logic [7:0] raw);
      cfg_t c;
      c = cfg_t'(raw);
      if (raw[CFG_PD] && raw[CFG_PU]) begin
         c.pu = 1'b0;
      end
      return c;
   endfunction

endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge
// One pad's input path: a SYNC_STAGES-deep synchroniser, a register holding
// the previous synchronised value, and rise/fall detection qualified by the
// pad's interrupt enable and polarity.
// Ports:
//   clk_i, rst_n   core clock, asynchronous active-low reset
//   pad_i          raw pad input (asynchronous to clk_i)
//   irq_en_i       interrupt enable for this pad
//   irq_fall_i     0 = detect rising edge, 1 = detect falling edge
//   sync_o         synchronised pad value
//   edge_o         one-cycle qualified edge indication (combinational)
module io_sync_edge
   import io_pad_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic pad_i,
   input  logic irq_en_i,
   input  logic irq_fall_i,
   output logic sync_o,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic                   prev_q;

   // Shift the raw pad value through the synchroniser; prev_q trails the
   // synchronised value by one cycle so a transition is visible for exactly
   // one cycle. prev_q always tracks, even while the interrupt is disabled,
   // so turning the interrupt on never reports an old level as an edge.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], pad_i};
         prev_q  <= chain_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = chain_q[SYNC_STAGES-1];

   // Pick rising or falling transition according to polarity, then gate
   // with the enable.
   always_comb begin
      edge_o = 1'b0;
      if (irq_en_i) begin
         if (irq_fall_i) begin
            edge_o = prev_q & ~sync_o;
         end else begin
            edge_o = ~prev_q & sync_o;
         end
      end
   end

endmodule

// File: rtl/io_pad_ctrl.sv
// io_pad_ctrl
// Pad-control stage for the bidirectional pad ring. Holds one config byte
// per pad (programmed over a valid/ready port), registers core output and
// output-enable onto the pads, synchronises pad inputs into the core domain
// and latches per-pad edge interrupts into sticky, write-1-to-clear status
// bits that are OR-ed onto a single registered irq line.
// Ports:
//   clk_i, rst_n                 core clock, asynchronous active-low reset
//   cfg_valid_i/cfg_ready_o      cfg request handshake
//   cfg_we_i, cfg_addr_i,        1 = write / 0 = read, address, write data
//   cfg_wdata_i
//   cfg_rvalid_o, cfg_rdata_o    read response, one cycle after accept
//   core_out_i, core_oe_i        core output values and enables
//   core_in_o                    synchronised pad inputs
//   irq_o                        OR of all pending status bits
//   io_in                        pad input values
//   io_out, io_oe, io_ie, io_pu, io_pd, io_cs, io_sl   pad control buses
module io_pad_ctrl
   import io_pad_pkg::*;
#(
   parameter int NUM_IO      = 43,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic              cfg_we_i,
   input  logic [5:0]        cfg_addr_i,
   input  logic [7:0]        cfg_wdata_i,
   output logic              cfg_rvalid_o,
   output logic [7:0]        cfg_rdata_o,
   input  logic [NUM_IO-1:0] core_out_i,
   input  logic [NUM_IO-1:0] core_oe_i,
   output logic [NUM_IO-1:0] core_in_o,
   output logic              irq_o,
   input  logic [NUM_IO-1:0] io_in,
   output logic [NUM_IO-1:0] io_out,
   output logic [NUM_IO-1:0] io_oe,
   output logic [NUM_IO-1:0] io_ie,
   output logic [NUM_IO-1:0] io_pu,
   output logic [NUM_IO-1:0] io_pd,
   output logic [NUM_IO-1:0] io_cs,
   output logic [NUM_IO-1:0] io_sl
);

   localparam logic [6:0] NUM_IO_W = 7'(NUM_IO);

   cfg_t              cfg_q [NUM_IO];
   logic [NUM_IO-1:0] status_q;
   logic [NUM_IO-1:0] edge_vec;
   logic [NUM_IO-1:0] clr_mask;
   logic [NUM_IO-1:0] oe_en_vec;
   logic [47:0]       status_pad;
   logic [7:0]        rd_mux;
   cfg_t              wr_cfg;
   logic              accept;
   logic              is_pad_addr;
   logic              is_status_addr;
   logic              wr_pad;
   logic              wr_status;

   // Transaction decode: one request per cycle, classified by address window
   assign accept         = cfg_valid_i & cfg_ready_o;
   assign is_pad_addr    = {1'b0, cfg_addr_i} < NUM_IO_W;
   assign is_status_addr = (cfg_addr_i >= STATUS_BASE) && (cfg_addr_i <= STATUS_LAST);
   assign wr_pad         = accept & cfg_we_i & is_pad_addr;
   assign wr_status      = accept & cfg_we_i & is_status_addr;
   assign wr_cfg         = sanitize_cfg(cfg_wdata_i);

   // Ready stays low for the first cycle after reset release, then is held
   // high forever; there is no back-pressure.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready_o <= 1'b0;
      end else begin
         cfg_ready_o <= 1'b1;
      end
   end

   // Per-pad configuration register file
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_IO; i++) begin
            cfg_q[i] <= cfg_t'(CFG_RESET);
         end
      end else begin
         for (int i = 0; i < NUM_IO; i++) begin
            if (wr_pad && (cfg_addr_i == 6'(i))) begin
               cfg_q[i] <= wr_cfg;
            end
         end
      end
   end

   // Static pad controls come straight from the config flops, so a write
   // shows on the pad buses in the cycle after it is accepted.
   always_comb begin
      io_ie     = '0;
      io_pu     = '0;
      io_pd     = '0;
      io_cs     = '0;
      io_sl     = '0;
      oe_en_vec = '0;
      for (int i = 0; i < NUM_IO; i++) begin
         io_ie[i]     = cfg_q[i].ie;
         io_pu[i]     = cfg_q[i].pu;
         io_pd[i]     = cfg_q[i].pd;
         io_cs[i]     = cfg_q[i].cs;
         io_sl[i]     = cfg_q[i].sl;
         oe_en_vec[i] = cfg_q[i].oe_en;
      end
   end

   // Core output data and enables are retimed by one flop before the pads
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         io_out <= '0;
         io_oe  <= '0;
      end else begin
         io_out <= core_out_i;
         io_oe  <= core_oe_i & oe_en_vec;
      end
   end

   // One synchroniser/edge detector per pad
   for (genvar g = 0; g < NUM_IO; g++) begin : g_pad
      io_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
         .clk_i      (clk_i),
         .rst_n      (rst_n),
         .pad_i      (io_in[g]),
         .irq_en_i   (cfg_q[g].irq_en),
         .irq_fall_i (cfg_q[g].irq_fall),
         .sync_o     (core_in_o[g]),
         .edge_o     (edge_vec[g])
      );
   end

   // Write-1-to-clear mask: status byte k covers pads 8k..8k+7
   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < NUM_IO; i++) begin
         clr_mask[i] = wr_status && (cfg_addr_i[2:0] == 3'(i / 8)) && cfg_wdata_i[i % 8];
      end
   end

   // Sticky status: the set term is OR-ed after the clear so an edge landing
   // in the same cycle as its clear is kept. Dropping IRQ_EN does not clear.
   // irq_o is a registered OR of all status bits.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
         irq_o    <= 1'b0;
      end else begin
         status_q <= (status_q & ~clr_mask) | edge_vec;
         irq_o    <= |status_q;
      end
   end

   // Read mux; unmapped addresses and status bits beyond the last pad read 0
   assign status_pad = 48'(status_q);

   always_comb begin
      rd_mux = '0;
      if (is_pad_addr) begin
         for (int i = 0; i < NUM_IO; i++) begin
            if (cfg_addr_i == 6'(i)) begin
               rd_mux = cfg_q[i];
            end
         end
      end else if (is_status_addr) begin
         case (cfg_addr_i[2:0])
            3'd0:    rd_mux = status_pad[7:0];
            3'd1:    rd_mux = status_pad[15:8];
            3'd2:    rd_mux = status_pad[23:16];
            3'd3:    rd_mux = status_pad[31:24];
            3'd4:    rd_mux = status_pad[39:32];
            3'd5:    rd_mux = status_pad[47:40];
            default: rd_mux = '0;
         endcase
      end
   end

   // Read response: captured at the accept edge, valid for one cycle.
   // The asynchronous reset drops any response still in flight.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cfg_rvalid_o <= 1'b0;
         cfg_rdata_o  <= '0;
      end else begin
         cfg_rvalid_o <= accept & ~cfg_we_i;
         if (accept && !cfg_we_i) begin
            cfg_rdata_o <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_io_pad_ctrl.sv
// tb_io_pad_ctrl
// Self-checking bench for io_pad_ctrl. Read requests push their expected
// data into a scoreboard queue; a monitor pops and compares whenever the
// DUT presents cfg_rvalid_o. Pad buses and irq are compared directly.
module tb_io_pad_ctrl;

   localparam int NUM_IO      = 43;
   localparam int SYNC_STAGES = 2;
   localparam logic [NUM_IO-1:0] ALL_ONES = {NUM_IO{1'b1}};

   logic              clk_i;
   logic              rst_n;
   logic              cfg_valid_i;
   logic              cfg_ready_o;
   logic              cfg_we_i;
   logic [5:0]        cfg_addr_i;
   logic [7:0]        cfg_wdata_i;
   logic              cfg_rvalid_o;
   logic [7:0]        cfg_rdata_o;
   logic [NUM_IO-1:0] core_out_i;
   logic [NUM_IO-1:0] core_oe_i;
   logic [NUM_IO-1:0] core_in_o;
   logic              irq_o;
   logic [NUM_IO-1:0] io_in;
   logic [NUM_IO-1:0] io_out;
   logic [NUM_IO-1:0] io_oe;
   logic [NUM_IO-1:0] io_ie;
   logic [NUM_IO-1:0] io_pu;
   logic [NUM_IO-1:0] io_pd;
   logic [NUM_IO-1:0] io_cs;
   logic [NUM_IO-1:0] io_sl;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q [$];
   string      tag_q [$];

   io_pad_ctrl #(
      .NUM_IO      (NUM_IO),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .cfg_we_i     (cfg_we_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .cfg_rvalid_o (cfg_rvalid_o),
      .cfg_rdata_o  (cfg_rdata_o),
      .core_out_i   (core_out_i),
      .core_oe_i    (core_oe_i),
      .core_in_o    (core_in_o),
      .irq_o        (irq_o),
      .io_in        (io_in),
      .io_out       (io_out),
      .io_oe        (io_oe),
      .io_ie        (io_ie),
      .io_pu        (io_pu),
      .io_pd        (io_pd),
      .io_cs        (io_cs),
      .io_sl        (io_sl)
   );

   // Free-running 10-unit clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [NUM_IO-1:0] bitAt(input int idx);
      logic [NUM_IO-1:0] one;
      one = {{(NUM_IO-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Issue one cfg transaction; reads register their expected data first
   task automatic applyStimulus(input logic we, input logic [5:0] addr, input logic [7:0] wdata,
                                input logic [7:0] exp, input string tag);
      if (!we) begin
         exp_q.push_back(exp);
         tag_q.push_back(tag);
      end
      cfg_valid_i = 1'b1;
      cfg_we_i    = we;
      cfg_addr_i  = addr;
      cfg_wdata_i = wdata;
      tick();
      cfg_valid_i = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_wdata_i = '0;
   endtask

   // Scoreboard monitor: every read response must match the oldest expectation
   always @(negedge clk_i) begin
      if (rst_n && cfg_rvalid_o) begin
         if (exp_q.size() == 0) begin
            checkOutput("rvalid_unexpected", 64'(cfg_rvalid_o), 64'd0);
         end else begin
            checkOutput(tag_q.pop_front(), 64'(cfg_rdata_o), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      cfg_valid_i = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_addr_i  = '0;
      cfg_wdata_i = '0;
      core_out_i  = '0;
      core_oe_i   = '0;
      io_in       = '0;

      // Reset values while held in reset
      #12;
      checkOutput("rst_io_ie", 64'(io_ie), 64'(ALL_ONES));
      checkOutput("rst_io_pu_pd_cs_sl", 64'(io_pu | io_pd | io_cs | io_sl), 64'd0);
      checkOutput("rst_io_out_oe", 64'(io_out | io_oe), 64'd0);
      checkOutput("rst_ready", 64'(cfg_ready_o), 64'd0);
      checkOutput("rst_irq", 64'(irq_o), 64'd0);
      checkOutput("rst_rvalid_rdata", {55'd0, cfg_rvalid_o, cfg_rdata_o}, 64'd0);
      checkOutput("rst_core_in", 64'(core_in_o), 64'd0);

      // Ready low for the first cycle after release, then high
      @(posedge clk_i);
      #1;
      rst_n = 1'b1;
      checkOutput("ready_first_cycle", 64'(cfg_ready_o), 64'd0);
      tick();
      checkOutput("ready_after", 64'(cfg_ready_o), 64'd1);
      applyStimulus(1'b0, 6'h00, 8'h00, 8'h01, "rd_pad0_reset");

      // PU and PD together: PD wins, stored PU cleared
      applyStimulus(1'b1, 6'h05, 8'h26, 8'h00, "wr_pad5");
      checkOutput("pad5_pd", 64'(io_pd), 64'(bitAt(5)));
      checkOutput("pad5_pu", 64'(io_pu), 64'd0);
      checkOutput("pad5_ie_off", 64'(io_ie), 64'(ALL_ONES & ~bitAt(5)));
      applyStimulus(1'b0, 6'h05, 8'h00, 8'h24, "rd_pad5");

      // Output path with OE_EN set, then OE_EN cleared
      core_oe_i  = bitAt(5) | bitAt(6);
      core_out_i = bitAt(5) | bitAt(6);
      tick();
      checkOutput("oe_gated", 64'(io_oe), 64'(bitAt(5)));
      checkOutput("out_pass", 64'(io_out), 64'(bitAt(5) | bitAt(6)));
      applyStimulus(1'b1, 6'h05, 8'h04, 8'h00, "wr_pad5_oe_off");
      tick();
      checkOutput("oe_disabled", 64'(io_oe), 64'd0);
      core_oe_i  = '0;
      core_out_i = '0;

      // Pad 9 rising-edge interrupt latency and W1C
      applyStimulus(1'b1, 6'h09, 8'h41, 8'h00, "wr_pad9");
      io_in[9] = 1'b1;
      tick();
      checkOutput("sync_pad9_early", 64'(core_in_o), 64'd0);
      tick();
      checkOutput("sync_pad9", 64'(core_in_o), 64'(bitAt(9)));
      tick();
      checkOutput("irq_pad9_early", 64'(irq_o), 64'd0);
      tick();
      checkOutput("irq_pad9", 64'(irq_o), 64'd1);
      applyStimulus(1'b0, 6'h31, 8'h00, 8'h02, "rd_status1_pad9");
      applyStimulus(1'b1, 6'h31, 8'h02, 8'h00, "w1c_pad9");
      tick();
      checkOutput("irq_cleared", 64'(irq_o), 64'd0);

      // Pad 12 falling-edge interrupt; pad 20 toggles without IRQ_EN
      applyStimulus(1'b1, 6'h0C, 8'hC1, 8'h00, "wr_pad12");
      io_in[12] = 1'b1;
      io_in[20] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("irq_rise_ignored", 64'(irq_o), 64'd0);
      applyStimulus(1'b0, 6'h31, 8'h00, 8'h00, "rd_status1_no_rise");
      applyStimulus(1'b0, 6'h32, 8'h00, 8'h00, "rd_status2_disabled");
      io_in[12] = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("irq_fall", 64'(irq_o), 64'd1);
      applyStimulus(1'b0, 6'h31, 8'h00, 8'h10, "rd_status1_fall");
      applyStimulus(1'b1, 6'h31, 8'h10, 8'h00, "w1c_pad12");
      tick();
      checkOutput("irq_pad12_cleared", 64'(irq_o), 64'd0);

      // New falling edge sets status on the same edge that the W1C lands
      io_in[12] = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      io_in[12] = 1'b0;
      tick();
      tick();
      applyStimulus(1'b1, 6'h31, 8'h10, 8'h00, "w1c_collide");
      applyStimulus(1'b0, 6'h31, 8'h00, 8'h10, "rd_status_set_wins");

      // Unmapped addresses read zero
      applyStimulus(1'b0, 6'h3F, 8'h00, 8'h00, "rd_0x3F");
      applyStimulus(1'b0, 6'h2B, 8'h00, 8'h00, "rd_0x2B");
      applyStimulus(1'b0, 6'h35, 8'h00, 8'h00, "rd_status5");

      // Reset right after a read accept: the response must never appear
      cfg_valid_i = 1'b1;
      cfg_we_i    = 1'b0;
      cfg_addr_i  = 6'h00;
      @(posedge clk_i);
      #1;
      rst_n       = 1'b0;
      cfg_valid_i = 1'b0;
      #1;
      checkOutput("rvalid_dropped", 64'(cfg_rvalid_o), 64'd0);
      tick();
      checkOutput("rvalid_dropped_late", 64'(cfg_rvalid_o), 64'd0);
      checkOutput("rst_again_ie", 64'(io_ie), 64'(ALL_ONES));
      checkOutput("rst_again_pd", 64'(io_pd), 64'd0);
      rst_n = 1'b1;
      tick();
      applyStimulus(1'b0, 6'h05, 8'h00, 8'h01, "rd_pad5_after_reset");
      applyStimulus(1'b0, 6'h31, 8'h00, 8'h00, "rd_status_after_reset");

      // Let outstanding responses drain, then everything expected must be seen
      for (int i = 0; i < 3; i++) tick();
      checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
